// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from a CPU-selected source page into OAM,
// one byte per CPU M-cycle, restartable by a write to FF46 at any time.
module oam_dma #(
    parameter int LEN = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        reg_write,
    input  logic [7:0]  reg_in,
    output logic [7:0]  reg_out,
    output logic        active,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_in,
    output logic        oam_write
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_idx;
    logic [7:0] r_page;
    logic [7:0] r_reg_out;
    logic       r_restart;
    logic       w_load;
    logic       w_last;

    // Pages E0..FF alias work RAM through the echo region.
    function automatic logic [7:0] fold_page(input logic [7:0] v);
        if (v >= 8'hE0) begin
            return v - 8'h20;
        end else begin
            return v;
        end
    endfunction

    assign w_load  = reg_write & tick;
    assign w_last  = (r_idx == LAST_IDX);
    assign reg_out = r_reg_out;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a CPU write always wins, even over the final byte
    always_comb begin
        w_next_state = r_state;
        if (w_load) begin
            w_next_state = S_ARM;
        end else if (tick) begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_ARM:   w_next_state = S_XFER;
                S_XFER:  w_next_state = w_last ? S_IDLE : S_XFER;
                default: w_next_state = S_IDLE;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Index, page, readback register and restart flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= 8'd0;
            r_page    <= 8'h00;
            r_reg_out <= 8'hFF;
            r_restart <= 1'b0;
        end else if (w_load) begin
            r_reg_out <= reg_in;
            r_page    <= fold_page(reg_in);
            r_idx     <= 8'd0;
            // Bus stays owned across an ARM that interrupts a running copy.
            r_restart <= (r_state == S_XFER) | ((r_state == S_ARM) & r_restart);
        end else if (tick) begin
            case (r_state)
                S_ARM: begin
                    r_idx     <= 8'd0;
                    r_restart <= 1'b0;
                end
                S_XFER: begin
                    r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        active    = 1'b0;
        src_addr  = 16'h0000;
        oam_addr  = 8'h00;
        oam_in    = 8'h00;
        oam_write = 1'b0;
        case (r_state)
            S_XFER: begin
                active    = 1'b1;
                src_addr  = {r_page, r_idx};
                oam_addr  = r_idx;
                oam_in    = src_data;
                oam_write = tick;
            end
            S_ARM: begin
                active = r_restart;
            end
            default: begin
                active = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: one task per scenario, inline checks against
// hand-derived addresses and a simple source-memory model.
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        reg_write;
    logic [7:0]  reg_in;
    logic [7:0]  reg_out;
    logic        active;
    logic [15:0] src_addr;
    logic [7:0]  src_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_in;
    logic        oam_write;

    int total = 0;
    int bad   = 0;

    logic        s_ow;
    logic        s_act;
    logic [15:0] s_sa;
    logic [7:0]  s_oa;
    logic [7:0]  s_oi;

    oam_dma #(.LEN(160)) dut (
        .clk(clk), .rst(rst), .tick(tick), .reg_write(reg_write),
        .reg_in(reg_in), .reg_out(reg_out), .active(active),
        .src_addr(src_addr), .src_data(src_data), .oam_addr(oam_addr),
        .oam_in(oam_in), .oam_write(oam_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign src_data = mem(src_addr);

    // One M-cycle: tick for one clk (outputs sampled mid-cycle), then three idle clks.
    task automatic mcycle(input logic wr, input logic [7:0] d);
        @(negedge clk);
        tick = 1'b1; reg_write = wr; reg_in = d;
        #1;
        s_ow = oam_write; s_act = active; s_sa = src_addr; s_oa = oam_addr; s_oi = oam_in;
        @(negedge clk);
        tick = 1'b0; reg_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; tick = 1'b0; reg_write = 1'b0; reg_in = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({reg_out, active, oam_write, src_addr} !== {8'hFF, 1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", {reg_out, active, oam_write, src_addr},
                     {8'hFF, 1'b0, 1'b0, 16'h0000});
        end
        rst = 1'b1;
        mcycle(1'b0, 8'h00);
        total++;
        if ({s_ow, s_act} !== 2'b00) begin
            bad++; $display("FAIL reset_idle got=%b exp=00", {s_ow, s_act});
        end
    endtask

    task automatic test_tick_gate();
        @(negedge clk);
        reg_write = 1'b1; reg_in = 8'hC4; tick = 1'b0;
        @(negedge clk);
        reg_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mcycle(1'b0, 8'h00);
            total++;
            if ({s_ow, s_act, reg_out} !== {1'b0, 1'b0, 8'hFF}) begin
                bad++; $display("FAIL tick_gate k=%0d got=%h exp=0ff", k, {s_ow, s_act, reg_out});
            end
        end
    endtask

    task automatic test_basic(input logic [7:0] wv, input logic [15:0] base, input string nm);
        mcycle(1'b1, wv);
        total++;
        if ({s_ow, s_act} !== 2'b00) begin
            bad++; $display("FAIL %s_write_cycle got=%b exp=00", nm, {s_ow, s_act});
        end
        mcycle(1'b0, 8'h00);
        total++;
        if ({s_ow, s_act, reg_out} !== {1'b0, 1'b0, wv}) begin
            bad++; $display("FAIL %s_arm got=%h exp=%h", nm, {s_ow, s_act, reg_out}, {1'b0, 1'b0, wv});
        end
        for (int i = 0; i < 160; i++) begin
            logic [15:0] ea;
            ea = base + 16'(i);
            mcycle(1'b0, 8'h00);
            total++;
            if ({s_ow, s_act, s_sa, s_oa, s_oi} !== {1'b1, 1'b1, ea, 8'(i), mem(ea)}) begin
                bad++;
                $display("FAIL %s_byte i=%0d got=%h exp=%h", nm, i, {s_ow, s_act, s_sa, s_oa, s_oi},
                         {1'b1, 1'b1, ea, 8'(i), mem(ea)});
            end
        end
        mcycle(1'b0, 8'h00);
        total++;
        if ({s_ow, s_act, s_sa} !== {1'b0, 1'b0, 16'h0000}) begin
            bad++; $display("FAIL %s_done got=%h exp=0", nm, {s_ow, s_act, s_sa});
        end
    endtask

    // Restart a running copy with a second write at byte rs_at of the first page.
    task automatic test_restart(input logic [7:0] w1, input logic [7:0] w2, input int rs_at,
                                input string nm);
        mcycle(1'b1, w1);
        mcycle(1'b0, 8'h00);
        for (int i = 0; i < rs_at; i++) mcycle(1'b0, 8'h00);
        mcycle(1'b1, w2);
        total++;
        if ({s_ow, s_sa, s_oa, s_oi} !== {1'b1, {w1, 8'(rs_at)}, 8'(rs_at), mem({w1, 8'(rs_at)})}) begin
            bad++;
            $display("FAIL %s_hit got=%h exp=%h", nm, {s_ow, s_sa, s_oa, s_oi},
                     {1'b1, {w1, 8'(rs_at)}, 8'(rs_at), mem({w1, 8'(rs_at)})});
        end
        mcycle(1'b0, 8'h00);
        total++;
        if ({s_ow, s_act, reg_out} !== {1'b0, 1'b1, w2}) begin
            bad++; $display("FAIL %s_arm got=%h exp=%h", nm, {s_ow, s_act, reg_out}, {1'b0, 1'b1, w2});
        end
        for (int i = 0; i < 160; i++) begin
            logic [15:0] ea;
            ea = {w2, 8'(i)};
            mcycle(1'b0, 8'h00);
            total++;
            if ({s_ow, s_act, s_sa, s_oa, s_oi} !== {1'b1, 1'b1, ea, 8'(i), mem(ea)}) begin
                bad++;
                $display("FAIL %s_byte i=%0d got=%h exp=%h", nm, i, {s_ow, s_act, s_sa, s_oa, s_oi},
                         {1'b1, 1'b1, ea, 8'(i), mem(ea)});
            end
        end
        mcycle(1'b0, 8'h00);
        total++;
        if ({s_ow, s_act} !== 2'b00) begin
            bad++; $display("FAIL %s_done got=%b exp=00", nm, {s_ow, s_act});
        end
    endtask

    task automatic test_reset_mid();
        mcycle(1'b1, 8'hC1);
        mcycle(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) mcycle(1'b0, 8'h00);
        @(negedge clk);
        tick = 1'b1;
        #1;
        total++;
        if ({oam_write, oam_addr} !== {1'b1, 8'd10}) begin
            bad++; $display("FAIL rstmid_pre got=%h exp=10a", {oam_write, oam_addr});
        end
        rst = 1'b0;
        #1;
        total++;
        if ({oam_write, active, src_addr} !== {1'b0, 1'b0, 16'h0000}) begin
            bad++; $display("FAIL rstmid_abort got=%h exp=0", {oam_write, active, src_addr});
        end
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if (reg_out !== 8'hFF) begin
            bad++; $display("FAIL rstmid_regout got=%h exp=ff", reg_out);
        end
        for (int k = 0; k < 4; k++) begin
            mcycle(1'b0, 8'h00);
            total++;
            if ({s_ow, s_act} !== 2'b00) begin
                bad++; $display("FAIL rstmid_idle k=%0d got=%b exp=00", k, {s_ow, s_act});
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_gate();
        test_basic(8'hC1, 16'hC100, "c1");
        test_basic(8'hFE, 16'hDE00, "fold");
        test_restart(8'hC0, 8'hD0, 50, "restart");
        test_reset_mid();
        test_restart(8'hC2, 8'hC3, 159, "lastbyte");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
